// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the unified-memory arbiter.
// Also holds the lane-replication helper used by byte-enable generation.
package mem_arb_pkg;

  localparam int unsigned DW     = 32;
  localparam int unsigned BEW    = 4;
  localparam int unsigned WAIT_W = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_IF_BUSY = 2'd1;
  localparam state_t ST_D_BUSY  = 2'd2;
  localparam state_t ST_RESP    = 2'd3;

  typedef logic [1:0] size_t;
  localparam size_t SZ_BYTE = 2'b00;
  localparam size_t SZ_HALF = 2'b01;
  localparam size_t SZ_WORD = 2'b10;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_t;

  // Memory-port command held stable for the life of a transaction.
  typedef struct packed {
    logic           we;
    logic [BEW-1:0] be;
    logic [DW-1:0]  wdata;
  } mem_cmd_t;

  // Copies the right-justified store datum onto every lane it may occupy.
  function automatic logic [DW-1:0] lane_replicate(input size_t sz, input logic [DW-1:0] d);
    case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/be_gen.sv
// Byte-enable, misalignment and store-lane generation for one access.
// Purely combinational so a future cache can reuse it.
module be_gen
  import mem_arb_pkg::*;
(
  input  size_t          i_size,
  input  logic [1:0]     i_addr_lo,
  input  logic [DW-1:0]  i_wdata,
  output logic [BEW-1:0] o_be_c,
  output logic           o_misaligned_c,
  output logic [DW-1:0]  o_wdata_c
);

  always_comb begin
    o_be_c         = '0;
    o_misaligned_c = 1'b0;
    o_wdata_c      = lane_replicate(i_size, i_wdata);
    case (i_size)
      SZ_BYTE: o_be_c = 4'b0001 << i_addr_lo;
      SZ_HALF: begin
        if (i_addr_lo[0]) o_misaligned_c = 1'b1;
        else              o_be_c         = 4'b0011 << {i_addr_lo[1], 1'b0};
      end
      SZ_WORD: begin
        if (i_addr_lo != 2'b00) o_misaligned_c = 1'b1;
        else                    o_be_c         = 4'b1111;
      end
      default: o_misaligned_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and load/store paths onto one single-port memory,
// with round-robin grant, misalignment rejection and a wait-state timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned AW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_valid,
  output logic          d_err,
  output logic          stall,
  output logic          bus_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  state_t            r_state;
  grant_t            r_last;
  logic [WAIT_W-1:0] r_wait;
  logic              r_mem_req;
  logic [AW-1:0]     r_mem_addr;
  mem_cmd_t          r_cmd;
  logic [31:0]       r_if_rdata;
  logic              r_if_valid;
  logic [31:0]       r_d_rdata;
  logic              r_d_valid;
  logic              r_d_err;
  logic              r_bus_err;

  state_t            w_state_nxt;
  logic              w_grant_if;
  logic              w_grant_d;
  logic              w_reject_d;
  logic              w_done;
  logic              w_abort;
  logic              w_busy;
  logic [WAIT_W-1:0] w_wait_inc;
  logic [3:0]        w_be;
  logic              w_misaligned;
  logic [31:0]       w_wdata_rep;
  logic              w_unused_if_addr;

  be_gen u_be_gen (
    .i_size         (d_size),
    .i_addr_lo      (d_addr[1:0]),
    .i_wdata        (d_wdata),
    .o_be_c         (w_be),
    .o_misaligned_c (w_misaligned),
    .o_wdata_c      (w_wdata_rep)
  );

  // Fetch addresses are word-aligned by construction; the low bits carry nothing.
  assign w_unused_if_addr = ^if_addr[1:0];

  assign w_busy     = (r_state == ST_IF_BUSY) || (r_state == ST_D_BUSY);
  assign w_wait_inc = r_wait + WAIT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state plus the one-hot events that drive the datapath registers.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_d   = 1'b0;
    w_reject_d  = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (if_req && (!d_req || (r_last == GNT_DATA))) begin
          w_grant_if  = 1'b1;
          w_state_nxt = ST_IF_BUSY;
        end else if (d_req) begin
          if (w_misaligned) begin
            w_reject_d  = 1'b1;
            w_state_nxt = ST_RESP;
          end else begin
            w_grant_d   = 1'b1;
            w_state_nxt = ST_D_BUSY;
          end
        end
      end
      ST_IF_BUSY, ST_D_BUSY: begin
        // A ready arriving on the limit cycle still completes normally.
        if (mem_ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_wait_inc == WAIT_LIMIT) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_cmd      <= '0;
      r_if_rdata <= '0;
      r_if_valid <= 1'b0;
      r_d_rdata  <= '0;
      r_d_valid  <= 1'b0;
      r_d_err    <= 1'b0;
      r_bus_err  <= 1'b0;
      r_wait     <= '0;
      r_last     <= GNT_DATA;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_d_err    <= 1'b0;

      if (w_grant_if) begin
        r_mem_req   <= 1'b1;
        r_mem_addr  <= {if_addr[AW-1:2], 2'b00};
        r_cmd.we    <= 1'b0;
        r_cmd.be    <= 4'b1111;
        r_cmd.wdata <= '0;
        r_wait      <= '0;
      end

      if (w_grant_d) begin
        r_mem_req   <= 1'b1;
        r_mem_addr  <= {d_addr[AW-1:2], 2'b00};
        r_cmd.we    <= d_we;
        r_cmd.be    <= w_be;
        r_cmd.wdata <= w_wdata_rep;
        r_wait      <= '0;
      end

      if (w_reject_d) begin
        r_d_valid <= 1'b1;
        r_d_err   <= 1'b1;
        r_d_rdata <= '0;
        r_last    <= GNT_DATA;
      end

      if (w_busy && !mem_ready && !w_abort) r_wait <= w_wait_inc;

      // Completion or timeout: release the port and answer the owner next cycle.
      if (w_done || w_abort) begin
        r_mem_req <= 1'b0;
        if (r_state == ST_IF_BUSY) begin
          r_if_valid <= 1'b1;
          r_if_rdata <= w_done ? mem_rdata : 32'd0;
          r_last     <= GNT_FETCH;
        end else begin
          r_d_valid <= 1'b1;
          r_d_err   <= w_abort;
          r_last    <= GNT_DATA;
          if (w_abort)        r_d_rdata <= '0;
          else if (!r_cmd.we) r_d_rdata <= mem_rdata;
        end
        if (w_abort) r_bus_err <= 1'b1;
      end
    end
  end

  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign d_rdata   = r_d_rdata;
  assign d_valid   = r_d_valid;
  assign d_err     = r_d_err;
  assign bus_err   = r_bus_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_cmd.we;
  assign mem_be    = r_cmd.be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_cmd.wdata;
  assign stall     = (if_req & ~r_if_valid) | (d_req & ~r_d_valid);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned MAXW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [31:0]   if_rdata;
  logic          if_valid;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [1:0]    d_size = 2'b00;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic [31:0]   d_rdata;
  logic          d_valid;
  logic          d_err;
  logic          stall;
  logic          bus_err;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          mem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_WAIT(MAXW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
    .stall(stall), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s no completion within cycle budget t=%0t", nm, $time);
  endtask

  // Memory responder: 0 always ready, 1 never, 2 random, 3 ready on the K-th cycle.
  int          ready_mode = 0;
  int          ready_k = 1;
  int          req_cnt = 0;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_data = '0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) req_cnt++;
      else         req_cnt = 0;
      case (ready_mode)
        0:       mem_ready = mem_req;
        1:       mem_ready = 1'b0;
        2:       mem_ready = mem_req && (($urandom % 3) == 0);
        default: mem_ready = mem_req && (req_cnt == ready_k);
      endcase
      mem_rdata = use_fixed ? fixed_data : $urandom;
    end
  end

  // Reference model: who owns the port, who is being answered, and what was latched.
  int          m_busy = -1;
  int          m_ans = -1;
  int          m_last = 1;
  int          m_wait = 0;
  bit          m_ans_err = 1'b0;
  bit          m_bus_err = 1'b0;
  bit          m_we = 1'b0;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_d_rdata = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_be = '0;

  int          stall_cycles = 0;
  int          memreq_cycles = 0;
  int          valid_pulses = 0;
  logic [31:0] seen_addr = '0;
  logic [3:0]  seen_be = '0;
  logic [31:0] seen_wdata = '0;

  initial begin
    forever begin
      @(negedge clk);
      chk("mem_req", 32'(mem_req), 32'(m_busy >= 0));
      if (m_busy >= 0) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_be", 32'(mem_be), 32'(m_be));
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("if_valid", 32'(if_valid), 32'(m_ans == 0));
      chk("d_valid", 32'(d_valid), 32'(m_ans == 1));
      chk("d_err", 32'(d_err), 32'((m_ans == 1) && m_ans_err));
      chk("if_rdata", if_rdata, m_if_rdata);
      chk("d_rdata", d_rdata, m_d_rdata);
      chk("bus_err", 32'(bus_err), 32'(m_bus_err));
      chk("stall", 32'(stall), 32'((if_req && (m_ans != 0)) || (d_req && (m_ans != 1))));

      if (stall) stall_cycles++;
      if (if_valid || d_valid) valid_pulses++;
      if (mem_req) begin
        memreq_cycles++;
        seen_addr  = mem_addr;
        seen_be    = mem_be;
        seen_wdata = mem_wdata;
      end

      if (reset) begin
        m_busy = -1; m_ans = -1; m_last = 1; m_wait = 0; m_bus_err = 1'b0;
        m_if_rdata = '0; m_d_rdata = '0; m_addr = '0; m_we = 1'b0; m_be = '0; m_wdata = '0;
      end else if (m_ans >= 0) begin
        m_ans = -1;
      end else if (m_busy >= 0) begin
        if (mem_ready) begin
          m_ans = m_busy; m_ans_err = 1'b0; m_last = m_busy;
          if (m_busy == 0)  m_if_rdata = mem_rdata;
          else if (!m_we)   m_d_rdata  = mem_rdata;
          m_busy = -1;
        end else if (m_wait + 1 >= int'(MAXW)) begin
          m_ans = m_busy; m_ans_err = 1'b1; m_last = m_busy; m_bus_err = 1'b1;
          if (m_busy == 0) m_if_rdata = '0;
          else             m_d_rdata  = '0;
          m_busy = -1;
        end else begin
          m_wait++;
        end
      end else begin
        int g;
        g = -1;
        if (if_req && d_req) g = 1 - m_last;
        else if (if_req)     g = 0;
        else if (d_req)      g = 1;
        if (g == 0) begin
          m_busy = 0; m_wait = 0; m_we = 1'b0; m_be = 4'hF;
          m_addr = if_addr & 32'hFFFF_FFFC;
        end else if (g == 1) begin
          int nb;
          logic [7:0] be8;
          nb = 1 << d_size;
          if ((d_size == 2'b11) || ((int'(d_addr[1:0]) % nb) != 0)) begin
            m_ans = 1; m_ans_err = 1'b1; m_d_rdata = '0; m_last = 1;
          end else begin
            m_busy = 1; m_wait = 0; m_we = d_we;
            m_addr = d_addr & 32'hFFFF_FFFC;
            be8    = 8'((1 << nb) - 1) << d_addr[1:0];
            m_be   = be8[3:0];
            case (d_size)
              2'b00:   m_wdata = 32'(d_wdata[7:0]) * 32'h0101_0101;
              2'b01:   m_wdata = 32'(d_wdata[15:0]) * 32'h0001_0001;
              default: m_wdata = d_wdata;
            endcase
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Latency counts clock edges from raising the request to seeing valid.
  task automatic do_fetch(input logic [31:0] a, output int lat, output logic [31:0] rd);
    if_req  = 1'b1;
    if_addr = a;
    lat = 0;
    rd  = '0;
    forever begin
      @(posedge clk);
      #1;
      lat++;
      if (if_valid) begin
        rd = if_rdata;
        break;
      end
      if (lat >= 300) begin
        bound_expired("fetch_wait");
        break;
      end
    end
    if_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic err,
                         output logic [31:0] rd);
    d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
    lat = 0;
    err = 1'b0;
    rd  = '0;
    forever begin
      @(posedge clk);
      #1;
      lat++;
      if (d_valid) begin
        err = d_err;
        rd  = d_rdata;
        break;
      end
      if (lat >= 300) begin
        bound_expired("data_wait");
        break;
      end
    end
    d_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          lf, ld, s0, q0, v0;
    logic [31:0] rf, rd;
    logic        e;

    idle(3);
    reset = 1'b0;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    // Single fetch, memory ready on its first cycle.
    ready_mode = 0; use_fixed = 1'b1; fixed_data = 32'h2008_0005;
    s0 = stall_cycles;
    do_fetch(32'h0000_0040, lf, rf);
    use_fixed = 1'b0;
    chk("fetch_latency", 32'(lf), 32'd2);
    chk("fetch_rdata", rf, 32'h2008_0005);
    chk("fetch_mem_addr", seen_addr, 32'h0000_0040);
    chk("fetch_mem_be", 32'(seen_be), 32'hF);
    chk("fetch_stall_cycles", 32'(stall_cycles - s0), 32'd2);
    idle(2);

    // Last grant was fetch: simultaneous requests go to data first.
    fork
      do_fetch(32'h0000_0100, lf, rf);
      do_data(1'b0, 2'b10, 32'h0000_0080, 32'd0, ld, e, rd);
    join
    chk("rr_data_first_lat", 32'(ld), 32'd2);
    chk("rr_fetch_second_lat", 32'(lf), 32'd5);
    idle(2);

    // After reset the fetch side wins a tie.
    do_reset();
    fork
      do_fetch(32'h0000_0104, lf, rf);
      do_data(1'b0, 2'b10, 32'h0000_0084, 32'd0, ld, e, rd);
    join
    chk("rst_fetch_first_lat", 32'(lf), 32'd2);
    chk("rst_data_second_lat", 32'(ld), 32'd5);
    idle(2);

    do_data(1'b1, 2'b00, 32'h0000_0103, 32'h0000_00AB, ld, e, rd);
    chk("sb_be", 32'(seen_be), 32'h8);
    chk("sb_wdata", seen_wdata, 32'hABAB_ABAB);
    chk("sb_err", 32'(e), 32'd0);
    idle(1);
    do_data(1'b1, 2'b01, 32'h0000_0102, 32'h0000_1234, ld, e, rd);
    chk("sh_be", 32'(seen_be), 32'hC);
    chk("sh_wdata", seen_wdata, 32'h1234_1234);
    chk("sh_addr", seen_addr, 32'h0000_0100);
    idle(1);

    // Misaligned accesses never reach the memory port.
    q0 = memreq_cycles;
    do_data(1'b0, 2'b10, 32'h0000_0102, 32'd0, ld, e, rd);
    chk("mis_lw_latency", 32'(ld), 32'd1);
    chk("mis_lw_err", 32'(e), 32'd1);
    chk("mis_lw_rdata", rd, 32'd0);
    idle(1);
    do_data(1'b1, 2'b11, 32'h0000_0100, 32'd7, ld, e, rd);
    chk("mis_reserved_err", 32'(e), 32'd1);
    chk("mis_no_mem_req", 32'(memreq_cycles - q0), 32'd0);
    idle(1);

    // Timeout, then ready exactly on the limit cycle, then a fetch timeout.
    ready_mode = 1;
    q0 = memreq_cycles;
    do_data(1'b0, 2'b10, 32'h0000_0200, 32'd0, ld, e, rd);
    chk("tmo_latency", 32'(ld), 32'd5);
    chk("tmo_err", 32'(e), 32'd1);
    chk("tmo_mem_req_cycles", 32'(memreq_cycles - q0), 32'd4);
    chk("tmo_bus_err", 32'(bus_err), 32'd1);
    idle(1);
    ready_mode = 3; ready_k = 4;
    do_data(1'b0, 2'b10, 32'h0000_0204, 32'd0, ld, e, rd);
    chk("edge_ready_err", 32'(e), 32'd0);
    chk("edge_ready_latency", 32'(ld), 32'd5);
    chk("bus_err_sticky", 32'(bus_err), 32'd1);
    idle(1);
    ready_mode = 1;
    do_fetch(32'h0000_0300, lf, rf);
    chk("fetch_tmo_rdata", rf, 32'd0);
    chk("fetch_tmo_latency", 32'(lf), 32'd5);
    idle(1);

    // Reset while a data access is waiting on memory.
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h0000_0400;
    idle(2);
    reset = 1'b1; d_req = 1'b0;
    v0 = valid_pulses;
    idle(1);
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_bus_err", 32'(bus_err), 32'd0);
    reset = 1'b0;
    idle(3);
    chk("midrst_no_valid", 32'(valid_pulses - v0), 32'd0);
    ready_mode = 0;
    do_fetch(32'h0000_0500, lf, rf);
    chk("midrst_fetch_latency", 32'(lf), 32'd2);
    idle(2);

    // Randomized concurrent traffic with random memory latency.
    ready_mode = 2;
    fork
      begin
        int          lat_f;
        logic [31:0] rd_f;
        for (int i = 0; i < 80; i++) begin
          idle(int'($urandom_range(1, 4)));
          do_fetch($urandom & 32'hFFFF_FFFC, lat_f, rd_f);
        end
      end
      begin
        int          lat_d, r;
        logic        err_d;
        logic [31:0] rd_d;
        logic [1:0]  sz;
        for (int j = 0; j < 80; j++) begin
          idle(int'($urandom_range(1, 4)));
          r  = int'($urandom % 8);
          sz = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
          do_data(1'($urandom % 2), sz, $urandom, $urandom, lat_d, err_d, rd_d);
        end
      end
    join
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the instruction-fetch path and the load/store path of the MIPS core.
- Arbitrates between the two requesters, generates byte enables for byte, half and word accesses, and detects misaligned accesses.
- Runs a per-transaction wait-state timeout and drives `stall`, which freezes PC and register write-back while an access is outstanding.

Parameters:
- MAX_WAIT, 16: memory cycles allowed without `mem_ready` before the transaction is aborted (range 1..255).
- AW, 32: address width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until `if_valid`.
- if_addr  in  AW  fetch address (word-aligned by construction).
- if_rdata  out  32  fetched instruction.
- if_valid  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  load/store request; held until `d_valid`.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned).
- d_addr  in  AW  byte address.
- d_wdata  in  32  store data, right-justified.
- d_rdata  out  32  raw memory word; extension is done in the datapath.
- d_valid  out  1  one-cycle completion pulse for data.
- d_err  out  1  qualifies `d_valid`: misaligned access or timeout.
- stall  out  1  combinational: `(if_req & ~if_valid) | (d_req & ~d_valid)`.
- bus_err  out  1  sticky timeout flag; cleared only by reset.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable.
- mem_be  out  4  byte lane enables.
- mem_addr  out  AW  word address: `{addr[AW-1:2], 2'b00}`.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  memory read data, valid when `mem_ready` is high.
- mem_ready  in  1  completes the current memory transaction.

Behaviour:
- **Reset:** all outputs are 0, FSM is IDLE, wait counter is 0, `bus_err` is 0, `last_grant` = DATA (so the first grant after reset goes to fetch).
- **States:**
  - IDLE: choose a grant.
  - IF_BUSY: fetch transaction on the memory port.
  - D_BUSY: data transaction on the memory port.
  - RESP: one cycle in which `if_valid` or `d_valid` is driven.
- **Grant in IDLE:**
  - Only one port requesting: grant it.
  - Both requesting: grant the port not in `last_grant` (round-robin).
  - The port being answered in RESP is ignored for that cycle. This prevents re-issuing a request whose `req` has not yet dropped.
- **Issue:** on the grant edge, register `mem_req`=1 together with `mem_addr`, `mem_we`, `mem_be`, `mem_wdata`. These stay stable until completion.
- **Fetch access:** `mem_we`=0, `mem_be`=1111.
- **Data access byte enables and data:**
  - Byte: `mem_be` = `0001 << addr[1:0]`; `mem_wdata` = byte replicated x4.
  - Half: `mem_be` = `0011 << {addr[1],1'b0}`; `mem_wdata` = half replicated x2.
  - Word: `mem_be` = 1111.
- **Misaligned data access** (half with `addr[0]`=1, word with `addr[1:0]`≠0, or size 11):
  - No memory access; IDLE goes directly to RESP.
  - `d_valid`=1, `d_err`=1, `d_rdata`=0.
  - `last_grant` is updated to DATA.
- **Completion:**
  - In a BUSY state, on the edge where `mem_ready`=1: capture `mem_rdata`, drop `mem_req`, go to RESP, update `last_grant`.
  - In RESP, `valid` is high for exactly one cycle; next state is IDLE.
  - Minimum latency from request to valid is 3 cycles (grant, memory cycle with `mem_ready`, RESP).
- **Wait counter:**
  - Cleared on grant; increments on each BUSY cycle with `mem_ready`=0.
  - When it reaches MAX_WAIT, the transaction aborts: drop `mem_req`, go to RESP with `err`=1 (fetch: `if_rdata`=0; data: `d_err`=1), and set `bus_err`.
  - `mem_ready` arriving in the same cycle as the limit wins: the transaction completes normally.
- **Stall:** `stall` stays 1 from request until the valid cycle inclusive-exclusive, i.e. it falls in the cycle `valid` is high.
- **Reset mid-transaction:** `mem_req` drops on the reset edge, no valid is generated, and the requesters restart.
- **Stores:** `d_rdata` is undefined (held at the previous value) on a store completion.

Decomposition:
- **Package `mem_arb_pkg`:**
  - `state_t` enum (IDLE, IF_BUSY, D_BUSY, RESP).
  - `size_t` encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - `grant_t` (FETCH, DATA).
- **Sub-module `be_gen`** (combinational): takes `size` and `addr[1:0]`, produces `be[3:0]`, `misaligned`, and lane-replicated `wdata`. It is reusable by a future cache.

Test Plan:
- **Single fetch:** reset, then `if_req`=1 with `if_addr`=0x0000_0040, memory answers `mem_ready` on the first cycle with 0x2008_0005 → `mem_addr`=0x40, `mem_be`=1111, `if_valid` 3 cycles after the request with `if_rdata`=0x2008_0005; `stall` high for 2 cycles.
- **Contention:** `if_req` and `d_req` both raised in the same cycle after reset → fetch is granted first, data second; a repeat of the same contention → data is granted first.
- **Byte/half stores:**
  - `sb` of 0xAB to 0x103 → `mem_be`=1000, `mem_wdata`=0xABAB_ABAB.
  - `sh` of 0x1234 to 0x102 → `mem_be`=1100, `mem_wdata`=0x1234_1234.
- **Misaligned:** `lw` with `d_addr`=0x102 → `mem_req` never rises; `d_valid`=`d_err`=1 two cycles after the request.
- **Timeout:** MAX_WAIT=4, `mem_ready` held at 0 → `mem_req` drops after 4 wait cycles, `d_valid` with `d_err`=1, `bus_err` stays 1 until reset.
- **Reset mid-transaction:** reset asserted in D_BUSY → `mem_req`=0 and `bus_err`=0 the next cycle, no valid pulse; the following fetch proceeds normally.
